sipo_deser: RTL
===============

# sipo_deser

Serial-in/parallel-out deserializer that assembles `LEN` serial bits into a word and presents it on a valid/ready output port. It sits directly upstream of the team's `LEN`-bit D-register capture stage and supplies the parallel data word that stage latches. A one-word output buffer plus input backpressure prevent any bit or word from being dropped.

## Interface
Parameters:
- `LEN`, 4, word width in bits; legal range 2..32.

Ports (one clock; reset is synchronous and active-high):
- `clk` input 1: single clock; all state updates on the rising edge.
- `clr` input 1: synchronous, active-high reset.
- `sin` input 1: serial data bit.
- `sin_vld` input 1: `sin` is valid this cycle.
- `sin_rdy` output 1: the block can accept a bit this cycle. A bit is accepted when `sin_vld && sin_rdy`.
- `out_data` output LEN: assembled word.
- `out_vld` output 1: `out_data` is valid.
- `out_rdy` input 1: downstream takes the word. A word transfers when `out_vld && out_rdy`.
- `out_perr` output 1: parity error flag for `out_data`. Meaningful only with `SIPO_PARITY_EN`.

## Operation
- Bit order is MSB first: the first accepted bit of a word becomes `out_data[LEN-1]` and the last becomes `out_data[0]`.
- Bit counter `bit_cnt` runs 0..LEN-1 and increments on each accepted data bit.
- The output slot is "free" in a cycle when `!out_vld || out_rdy`.
- State machine:
  - COLLECT:
    - `sin_rdy`=1.
    - An accepted bit shifts in.
    - On the last data bit (`bit_cnt==LEN-1`), `bit_cnt` resets to 0.
    - Next state is PARITY when `SIPO_PARITY_EN` is defined.
    - Otherwise the word completes this cycle.
  - PARITY (present only with the macro):
    - `sin_rdy`=1.
    - The accepted bit is the parity bit, and the word completes.
  - FULL:
    - `sin_rdy`=0.
    - A complete word waits in the shift register.
    - In a cycle when the slot is free, the word loads into `out_data` and the next state is COLLECT.
- Word completion:
  - If the slot is free in the completion cycle, the word loads into `out_data`/`out_vld` at that edge and the next state is COLLECT.
  - Otherwise the next state is FULL.
- `out_vld` clears on a transfer unless a new word loads at the same edge, in which case it stays 1 with the new data.
- `out_data` and `out_perr` hold stable while `out_vld && !out_rdy`.
- `sin` is ignored when `sin_vld`=0 or `sin_rdy`=0. No bit is consumed in those cycles.
- Reset values:
  - `out_vld`=0, `out_data`=0, `out_perr`=0.
  - `bit_cnt`=0, state COLLECT, so `sin_rdy`=1 in the first cycle after reset.
  - A partial word or buffered word in flight at reset is discarded.

## Timing
- Latency: `out_vld` rises at the clock edge that accepts the word's final bit (last data bit, or the parity bit). The word is visible from the next cycle.
- Throughput: one bit per cycle sustained while `out_rdy`=1, with no gap between words.
- `sin_rdy` is combinational from state only (low only in FULL); there is no combinational path from `out_rdy`.
- Simultaneous events:
  - Word completion and drain of the previous word in the same cycle: the new word loads with no bubble.
  - A drain while in FULL: `sin_rdy` returns to 1 in the following cycle.
- `clr` overrides every other input in the same cycle.

## Configuration
- `SIPO_PARITY_EN` defined:
  - Each word is followed by one even-parity bit.
  - `out_perr` = XOR of the LEN data bits and the parity bit, registered together with `out_data`.
  - A word occupies LEN+1 serial bits.
- Not defined:
  - No PARITY state; a word occupies exactly LEN bits.
  - `out_perr` is constant 0.

## Test plan
All scenarios use `LEN`=4.
- Reset: hold `clr`=1 with arbitrary inputs for 3 cycles, then release -> `out_vld`=0, `out_data`=4'h0, `out_perr`=0, `sin_rdy`=1.
- Basic: `out_rdy`=1, send bits 1,0,1,1 on consecutive cycles -> `out_vld`=1 with `out_data`=4'hB in the cycle after the 4th bit, for exactly 1 cycle.
- Backpressure:
  - Hold `out_rdy`=0 and send 8 bits (4'hB then 4'h6) -> after the second word completes, `sin_rdy`=0, `out_data` stays 4'hB, and further `sin_vld` bits are ignored.
  - Raise `out_rdy` for 1 cycle -> `out_data`=4'h6 on the next cycle and `sin_rdy`=1.
- Gaps: 4'hA sent with `sin_vld`=0 bubbles between each bit -> `out_data`=4'hA and `bit_cnt` advances only on valid bits.
- Mid-word reset: send 2 bits, pulse `clr`, then send 1,1,0,0 -> `out_data`=4'hC with no residue from the discarded bits.
- Parity (`SIPO_PARITY_EN` defined):
  - Send 1,0,1,1 then parity 1 -> `out_data`=4'hB, `out_perr`=0.
  - Same data with parity 0 -> `out_perr`=1.

Source files
------------

// File: rtl/sipo_deser.sv
// MSB-first serial-to-parallel deserializer with a one-word valid/ready output buffer.
// Optional even parity check on each word is enabled by defining SIPO_PARITY_EN.
module sipo_deser #(
  parameter int LEN = 4
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           sin,
  input  logic           sin_vld,
  output logic           sin_rdy,
  output logic [LEN-1:0] out_data,
  output logic           out_vld,
  input  logic           out_rdy,
  output logic           out_perr
);

  localparam int CW = (LEN > 2) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(LEN - 1);

  localparam logic [1:0] COLLECT = 2'd0;
  localparam logic [1:0] FULL    = 2'd2;
`ifdef SIPO_PARITY_EN
  localparam logic [1:0] PARITY  = 2'd1;
`endif

  logic [1:0]     state;
  logic [CW-1:0]  bit_cnt;
  logic [LEN-1:0] sreg;
  logic           acc;
  logic           slot_free;
  logic           last;
  logic [LEN-1:0] shifted;
  logic           done;
  logic [LEN-1:0] done_word;
  logic           done_perr;

  assign sin_rdy   = (state != FULL);
  assign acc       = sin_vld && sin_rdy;
  assign slot_free = !out_vld || out_rdy;
  assign last      = (bit_cnt == LAST);
  assign shifted   = {sreg[LEN-2:0], sin};

`ifdef SIPO_PARITY_EN
  logic perr_hold;
  logic perr_q;

  assign done      = acc && (state == PARITY);
  assign done_word = sreg;
  assign done_perr = (^sreg) ^ sin;
  assign out_perr  = perr_q;
`else
  assign done      = acc && (state == COLLECT) && last;
  assign done_word = shifted;
  assign done_perr = 1'b0;
  assign out_perr  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= COLLECT;
      bit_cnt  <= '0;
      sreg     <= '0;
      out_data <= '0;
      out_vld  <= 1'b0;
`ifdef SIPO_PARITY_EN
      perr_hold <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      // A transfer empties the slot; a load below may refill it at the same edge.
      if (out_vld && out_rdy) out_vld <= 1'b0;

      if (state == COLLECT && acc) begin
        sreg    <= shifted;
        bit_cnt <= last ? '0 : bit_cnt + 1'b1;
`ifdef SIPO_PARITY_EN
        if (last) state <= PARITY;
`endif
      end

      if (done) begin
        if (slot_free) begin
          out_data <= done_word;
          out_vld  <= 1'b1;
          state    <= COLLECT;
`ifdef SIPO_PARITY_EN
          perr_q   <= done_perr;
`endif
        end else begin
          state <= FULL;
`ifdef SIPO_PARITY_EN
          perr_hold <= done_perr;
`endif
        end
      end

      if (state == FULL && slot_free) begin
        out_data <= sreg;
        out_vld  <= 1'b1;
        state    <= COLLECT;
`ifdef SIPO_PARITY_EN
        perr_q   <= perr_hold;
`endif
      end
    end
  end

endmodule
